// File: rtl/sva_delay_obligation_tracker_if.sv
// Handshake bundle for the a |-> ##[1:N] b obligation tracker.
// Master drives the sampled stimulus; slave reports verdicts.
interface sva_delay_obligation_tracker_if #(
  parameter int MAX_DELAY = 4,
  parameter int CNT_W     = 16
);
  localparam int PW = $clog2(MAX_DELAY + 1);

  logic          en;
  logic          a;
  logic          b;
  logic          eot;
  logic          pass_o;
  logic          fail_o;
  logic [PW-1:0] pending;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic          done;

  modport master (
    output en, a, b, eot,
    input  pass_o, fail_o, pending,
    input  pass_cnt, fail_cnt, done
  );

  modport slave (
    input  en, a, b, eot,
    output pass_o, fail_o, pending,
    output pass_cnt, fail_cnt, done
  );
endinterface

// File: rtl/sva_delay_obligation_tracker.sv
// Checker for a |-> ##[1:MAX_DELAY] b with strong/weak eot.
// One slot per open attempt, aged by a shift each edge.
module sva_delay_obligation_tracker #(
  parameter int MAX_DELAY = 4,
  parameter bit STRONG    = 1'b1,
  parameter int CNT_W     = 16
) (
  input logic clk,
  input logic rst,
  sva_delay_obligation_tracker_if.slave bus
);
  localparam int PW = $clog2(MAX_DELAY + 1);
  localparam int SW = CNT_W + PW + 1;
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic {RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [MAX_DELAY:1] v_q, v_d;
  logic [MAX_DELAY:1] live;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              done_q, done_d;
  logic [PW-1:0]     pend_q, pend_d;
  logic [CNT_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0]  fc_q, fc_d;
  logic [PW-1:0]     npass, nfail, rem;

  function automatic logic [PW-1:0] popcnt(
    input logic [MAX_DELAY:1] x
  );
    logic [PW-1:0] n;
    n = '0;
    for (int k = 1; k <= MAX_DELAY; k++)
      n = n + PW'(x[k]);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] c,
    input logic [PW-1:0]    d
  );
    logic [SW-1:0] s;
    s = SW'(c) + SW'(d);
    return (s > SW'(CMAX)) ? CMAX : s[CNT_W-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    done_d  = done_q;
    pend_d  = '0;
    pc_d    = pc_q;
    fc_d    = fc_q;
    live    = '0;
    npass   = '0;
    nfail   = '0;
    rem     = '0;
    unique case (state_q)
      RUN: begin
        npass = bus.b ? popcnt(v_q) : '0;
        nfail = PW'(~bus.b & v_q[MAX_DELAY]);
        // slots still open after this edge, minus the one just expired
        live  = v_q & {MAX_DELAY{~bus.b}};
        live[MAX_DELAY] = 1'b0;
        v_d[1] = bus.a & bus.en;
        for (int k = 2; k <= MAX_DELAY; k++)
          v_d[k] = v_q[k-1] & ~bus.b;
        if (bus.eot) begin
          if (STRONG)
            rem = popcnt(live);
          v_d     = '0;
          state_d = DONE;
          done_d  = 1'b1;
        end
        pass_d = (npass != '0);
        fail_d = (nfail != '0) | (rem != '0);
        pc_d   = sat_add(pc_q, npass);
        fc_d   = sat_add(fc_q, nfail + rem);
        pend_d = popcnt(v_d);
      end
      DONE: begin
        v_d = '0;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      v_q     <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= '0;
      pc_q    <= '0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      pc_q    <= pc_d;
      fc_q    <= fc_d;
    end
  end

  assign bus.pass_o   = pass_q;
  assign bus.fail_o   = fail_q;
  assign bus.pending  = pend_q;
  assign bus.pass_cnt = pc_q;
  assign bus.fail_cnt = fc_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_sva_delay_obligation_tracker.sv
// Bench for the obligation tracker: strong and weak instances
// driven in lockstep, checked against vectors and a queue model.
module tb_sva_delay_obligation_tracker;
  localparam int MD   = 4;
  localparam int CW   = 16;
  localparam int CMAX = 65535;

  logic clk;
  logic rst;
  logic s_a, s_b, s_en, s_eot;

  int n_chk;
  int n_fail;

  sva_delay_obligation_tracker_if #(.MAX_DELAY(MD), .CNT_W(CW)) ifs();
  sva_delay_obligation_tracker_if #(.MAX_DELAY(MD), .CNT_W(CW)) ifw();

  assign ifs.a   = s_a;
  assign ifs.b   = s_b;
  assign ifs.en  = s_en;
  assign ifs.eot = s_eot;
  assign ifw.a   = s_a;
  assign ifw.b   = s_b;
  assign ifw.en  = s_en;
  assign ifw.eot = s_eot;

  sva_delay_obligation_tracker #(
    .MAX_DELAY(MD), .STRONG(1'b1), .CNT_W(CW)
  ) u_strong (
    .clk(clk), .rst(rst), .bus(ifs)
  );

  sva_delay_obligation_tracker #(
    .MAX_DELAY(MD), .STRONG(1'b0), .CNT_W(CW)
  ) u_weak (
    .clk(clk), .rst(rst), .bus(ifw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: queue of start-edge numbers of open attempts
  int q[$];
  int edge_n;
  bit m_done;
  int m_pc, m_fcs, m_fcw;
  bit m_po, m_fos, m_fow;

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  task automatic model_reset();
    q.delete();
    m_done = 1'b0;
    m_pc = 0; m_fcs = 0; m_fcw = 0;
    m_po = 1'b0; m_fos = 1'b0; m_fow = 1'b0;
  endtask

  task automatic model_edge(input bit a, b, en, eot);
    int np, nf, rem;
    edge_n++;
    m_po = 1'b0; m_fos = 1'b0; m_fow = 1'b0;
    if (m_done) return;
    np = b ? q.size() : 0;
    if (b) q.delete();
    nf = 0;
    if (!b && q.size() > 0 && q[0] <= edge_n - MD) begin
      nf = 1;
      void'(q.pop_front());
    end
    m_po  = (np != 0);
    m_fos = (nf != 0);
    m_fow = (nf != 0);
    m_pc  = sat(m_pc + np);
    m_fcw = sat(m_fcw + nf);
    if (eot) begin
      rem = q.size();
      m_fcs = sat(m_fcs + nf + rem);
      if (rem != 0) m_fos = 1'b1;
      q.delete();
      m_done = 1'b1;
    end else begin
      m_fcs = sat(m_fcs + nf);
      if (a && en) q.push_back(edge_n);
    end
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_model();
    chk("s_pass_o", 32'(ifs.pass_o), 32'(m_po));
    chk("w_pass_o", 32'(ifw.pass_o), 32'(m_po));
    chk("s_fail_o", 32'(ifs.fail_o), 32'(m_fos));
    chk("w_fail_o", 32'(ifw.fail_o), 32'(m_fow));
    chk("s_pending", 32'(ifs.pending), 32'(q.size()));
    chk("w_pending", 32'(ifw.pending), 32'(q.size()));
    chk("s_pass_cnt", 32'(ifs.pass_cnt), 32'(m_pc));
    chk("w_pass_cnt", 32'(ifw.pass_cnt), 32'(m_pc));
    chk("s_fail_cnt", 32'(ifs.fail_cnt), 32'(m_fcs));
    chk("w_fail_cnt", 32'(ifw.fail_cnt), 32'(m_fcw));
    chk("s_done", 32'(ifs.done), 32'(m_done));
    chk("w_done", 32'(ifw.done), 32'(m_done));
  endtask

  task automatic step(input bit a, b, en, eot);
    s_a = a; s_b = b; s_en = en; s_eot = eot;
    @(posedge clk);
    model_edge(a, b, en, eot);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    s_a = 1'b0; s_b = 1'b0; s_en = 1'b0; s_eot = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_model();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_s_pass_o"}, 32'(ifs.pass_o), 0);
    chk({tag, "_s_fail_o"}, 32'(ifs.fail_o), 0);
    chk({tag, "_s_pending"}, 32'(ifs.pending), 0);
    chk({tag, "_s_pass_cnt"}, 32'(ifs.pass_cnt), 0);
    chk({tag, "_s_fail_cnt"}, 32'(ifs.fail_cnt), 0);
    chk({tag, "_s_done"}, 32'(ifs.done), 0);
    chk({tag, "_w_pending"}, 32'(ifw.pending), 0);
    chk({tag, "_w_pass_cnt"}, 32'(ifw.pass_cnt), 0);
  endtask

  typedef struct {
    bit a, b, en, eot;
    bit po, fo;
    int pend, pc, fc;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int eot_at;
    n_chk = 0;
    n_fail = 0;
    edge_n = 0;
    rst = 1'b1;
    s_a = 1'b0; s_b = 1'b0; s_en = 1'b0; s_eot = 1'b0;

    tbl[0]  = '{1,0,1,0, 0,0,1,0,0};
    tbl[1]  = '{0,0,1,0, 0,0,1,0,0};
    tbl[2]  = '{0,1,1,0, 1,0,0,1,0};
    tbl[3]  = '{0,0,1,0, 0,0,0,1,0};
    tbl[4]  = '{1,0,1,0, 0,0,1,1,0};
    tbl[5]  = '{0,0,1,0, 0,0,1,1,0};
    tbl[6]  = '{0,0,1,0, 0,0,1,1,0};
    tbl[7]  = '{0,0,1,0, 0,0,1,1,0};
    tbl[8]  = '{0,0,1,0, 0,1,0,1,1};
    tbl[9]  = '{1,0,1,0, 0,0,1,1,1};
    tbl[10] = '{1,0,1,0, 0,0,2,1,1};
    tbl[11] = '{1,1,1,0, 1,0,1,3,1};
    tbl[12] = '{0,0,1,0, 0,0,1,3,1};
    tbl[13] = '{0,0,1,0, 0,0,1,3,1};
    tbl[14] = '{0,0,1,0, 0,0,1,3,1};
    tbl[15] = '{0,0,1,0, 0,1,0,3,2};
    tbl[16] = '{1,0,0,0, 0,0,0,3,2};
    tbl[17] = '{1,0,0,0, 0,0,0,3,2};
    tbl[18] = '{1,0,0,0, 0,0,0,3,2};
    tbl[19] = '{0,0,1,0, 0,0,0,3,2};

    #2;
    chk_zero("rst_hold");
    do_reset();

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].a, tbl[i].b, tbl[i].en, tbl[i].eot);
      chk($sformatf("v%0d_pass_o", i), 32'(ifs.pass_o), 32'(tbl[i].po));
      chk($sformatf("v%0d_fail_o", i), 32'(ifs.fail_o), 32'(tbl[i].fo));
      chk($sformatf("v%0d_pending", i), 32'(ifs.pending), 32'(tbl[i].pend));
      chk($sformatf("v%0d_pass_cnt", i), 32'(ifw.pass_cnt), 32'(tbl[i].pc));
      chk($sformatf("v%0d_fail_cnt", i), 32'(ifw.fail_cnt), 32'(tbl[i].fc));
    end

    // strong vs weak end of test with one attempt still open
    do_reset();
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    chk("eot_s_fail_o", 32'(ifs.fail_o), 1);
    chk("eot_s_fail_cnt", 32'(ifs.fail_cnt), 1);
    chk("eot_w_fail_o", 32'(ifw.fail_o), 0);
    chk("eot_w_fail_cnt", 32'(ifw.fail_cnt), 0);
    chk("eot_s_done", 32'(ifs.done), 1);
    chk("eot_w_done", 32'(ifw.done), 1);
    step(1, 1, 1, 0);
    chk("post_s_fail_o", 32'(ifs.fail_o), 0);
    chk("post_s_pass_o", 32'(ifs.pass_o), 0);
    step(1, 0, 1, 1);
    step(0, 0, 1, 0);
    chk("re_eot_s_fail_cnt", 32'(ifs.fail_cnt), 1);
    chk("re_eot_s_pending", 32'(ifs.pending), 0);

    // eot with b discharging every open attempt leaves nothing for strong
    do_reset();
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 1, 1, 1);
    chk("eotb_s_pass_o", 32'(ifs.pass_o), 1);
    chk("eotb_s_fail_cnt", 32'(ifs.fail_cnt), 0);
    chk("eotb_s_pass_cnt", 32'(ifs.pass_cnt), 2);

    // async reset with three open attempts
    do_reset();
    step(1, 0, 1, 0);
    step(0, 1, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    chk("pre_rst_pending", 32'(ifs.pending), 3);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    do_reset();
    step(0, 0, 1, 0);

    for (int r = 0; r < 4; r++) begin
      do_reset();
      eot_at = (r == 3) ? 1000 : int'($urandom_range(50, 250));
      for (int i = 0; i < 300; i++)
        step(1'($urandom % 2), ($urandom % 4) == 0,
             ($urandom % 5) != 0, i == eot_at);
    end

    // saturation: one pass per edge
    do_reset();
    for (int i = 0; i < 65540; i++)
      step(1, 1, 1, 0);
    chk("sat_pass_cnt", 32'(ifs.pass_cnt), 32'(CMAX));
    step(1, 1, 1, 0);
    chk("sat_hold", 32'(ifw.pass_cnt), 32'(CMAX));
    step(0, 0, 1, 1);
    chk("sat_eot_done", 32'(ifs.done), 1);
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    chk("sat_ignore_pass_o", 32'(ifs.pass_o), 0);
    chk("sat_ignore_pending", 32'(ifs.pending), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
